// File: rtl/qc_enc_pkg.sv
// ----------------------------------------------------------------------------
// qc_enc_pkg
//   Shared types and helpers for the quasi-cyclic LDPC parity encoder.
//   - state_t   : encoder FSM states
//   - cnt_width : counter width for a 0..n-1 counter, never less than 1 bit
// ----------------------------------------------------------------------------
package qc_enc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ACCUM = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/qc_circ_mac.sv
// ----------------------------------------------------------------------------
// qc_circ_mac
//   One parity circulant block. Holds the current generator row (already
//   rotated to the current beat position) and a Z-bit parity accumulator.
//   Each accepted beat XORs the P-lane product into the accumulator and
//   advances the row by P positions.
// Ports
//   clk     in   1   clock
//   rst     in   1   synchronous active-high reset
//   load    in   1   capture row_in into the row register
//   row_in  in   Z   generator first-row for the current info column
//   step    in   1   an info beat is accepted this cycle
//   first   in   1   first beat of the frame: overwrite acc instead of XOR
//   clear   in   1   zero the accumulator (final parity word handed off)
//   data    in   P   info bits of the beat, data[0] earliest
//   acc     out  Z   parity accumulator
// ----------------------------------------------------------------------------
module qc_circ_mac #(
    parameter int Z = 256,
    parameter int P = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [Z-1:0] row_in,
    input  logic         step,
    input  logic         first,
    input  logic         clear,
    input  logic [P-1:0] data,
    output logic [Z-1:0] acc
);

    logic [Z-1:0] row_q;
    logic [Z-1:0] prod;

    // Result bit i takes source bit (i-n) mod Z, so info bit t lands the
    // generator row on acc[i] as g[(i-t) mod Z].
    function automatic logic [Z-1:0] rot_up(input logic [Z-1:0] v, input int n);
        logic [Z-1:0] r;
        for (int i = 0; i < Z; i++) begin
            r[i] = v[(i + Z - n) % Z];
        end
        return r;
    endfunction

    // row_q already carries the beat offset b*P; lane j adds a further j.
    always_comb begin
        prod = '0;
        for (int j = 0; j < P; j++) begin
            if (data[j]) begin
                prod = prod ^ rot_up(row_q, j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            acc   <= '0;
        end else begin
            if (load) begin
                row_q <= row_in;
            end else if (step) begin
                row_q <= rot_up(row_q, P);
            end

            if (clear) begin
                acc <= '0;
            end else if (step) begin
                acc <= first ? prod : (acc ^ prod);
            end
        end
    end

endmodule

// File: rtl/qc_ldpc_encoder.sv
// ----------------------------------------------------------------------------
// qc_ldpc_encoder
//   Quasi-cyclic LDPC parity encoder. Takes K = KB*Z info bits at P bits per
//   beat, accumulates M = MB*Z parity bits from rotated circulant generator
//   rows, then streams the parity out P bits per beat (block 0 first, LSW
//   first within a block).
//
//   Generator rows come from GEN_ROWS: entry kb*MB+mb occupies bits
//   [(kb*MB+mb)*Z +: Z] and holds the first row of circulant (kb, mb).
//
//   Optional build macro QC_ENC_SYSTEMATIC_EN: info words are echoed on
//   out_data while they are accepted (in_ready then follows out_ready), so the
//   output stream is the full systematic codeword, info then parity.
//
// Ports
//   clk            in   1   clock
//   rst            in   1   synchronous active-high reset
//   in_data        in   P   info bits, in_data[0] earliest
//   in_valid       in   1   info word valid
//   in_ready       out  1   encoder accepts info word
//   out_data       out  P   output word
//   out_valid      out  1   output word valid
//   out_ready      in   1   downstream accepts output word
//   out_is_parity  out  1   out_data carries parity
//   out_last       out  1   last word of the codeword
//   busy           out  1   frame in progress
//
// FSM
//   state | meaning
//   IDLE  | waiting for in_valid; nothing consumed
//   LOAD  | one cycle: latch generator rows of column kb into the MACs
//   ACCUM | accepting Z/P info beats of column kb
//   DRAIN | streaming MB*Z/P parity words
// ----------------------------------------------------------------------------
module qc_ldpc_encoder
    import qc_enc_pkg::*;
#(
    parameter int Z  = 256,
    parameter int P  = 8,
    parameter int KB = 4,
    parameter int MB = 1,
    parameter logic [KB*MB*Z-1:0] GEN_ROWS = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [P-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [P-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_is_parity,
    output logic         out_last,
    output logic         busy
);

    localparam int BEATS       = Z / P;
    localparam int DRAIN_BEATS = MB * BEATS;
    localparam int BW          = cnt_width(BEATS);
    localparam int KW          = cnt_width(KB);
    localparam int DW          = cnt_width(DRAIN_BEATS);

    state_t          state;
    logic [BW-1:0]   beat_cnt;
    logic [KW-1:0]   kb_cnt;
    logic [DW-1:0]   drain_cnt;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            out_is_par_q;
    logic            busy_q;

    logic            in_fire;
    logic            out_fire;
    logic            mac_load;
    logic            mac_step;
    logic            mac_first;
    logic            mac_clear;
    logic [MB-1:0][Z-1:0] gen_sel;
    logic [MB-1:0][Z-1:0] acc_blk;
    logic [MB*Z-1:0] acc_flat;
    logic [P-1:0]    par_word;

`ifdef QC_ENC_SYSTEMATIC_EN
    assign in_ready  = in_ready_q & out_ready;
    assign out_valid = out_valid_q | (in_ready_q & in_valid);
    assign out_data  = in_ready_q ? in_data : par_word;
`else
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = par_word;
`endif
    assign out_is_parity = out_is_par_q;
    assign out_last      = out_last_q;
    assign busy          = busy_q;

    // Drain handshakes only; echoed info words complete through in_fire.
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid_q & out_ready;
    assign mac_load  = (state == LOAD);
    assign mac_step  = (state == ACCUM) & in_fire;
    assign mac_first = mac_step & (kb_cnt == '0) & (beat_cnt == '0);
    assign mac_clear = out_fire & out_last_q;

    always_comb begin
        gen_sel = '0;
        for (int k = 0; k < KB; k++) begin
            if (kb_cnt == KW'(k)) begin
                for (int m = 0; m < MB; m++) begin
                    gen_sel[m] = GEN_ROWS[(k*MB + m)*Z +: Z];
                end
            end
        end
    end

    for (genvar m = 0; m < MB; m++) begin : g_mac
        qc_circ_mac #(
            .Z (Z),
            .P (P)
        ) u_mac (
            .clk    (clk),
            .rst    (rst),
            .load   (mac_load),
            .row_in (gen_sel[m]),
            .step   (mac_step),
            .first  (mac_first),
            .clear  (mac_clear),
            .data   (in_data),
            .acc    (acc_blk[m])
        );
    end

    // Block mb sits at bits [mb*Z +: Z], so a linear word index walks the
    // parity mb-major, least-significant word first.
    assign acc_flat = acc_blk;

    always_comb begin
        par_word = '0;
        for (int n = 0; n < DRAIN_BEATS; n++) begin
            if (out_valid_q && (drain_cnt == DW'(n))) begin
                par_word = acc_flat[n*P +: P];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            kb_cnt       <= '0;
            drain_cnt    <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_is_par_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state  <= LOAD;
                        busy_q <= 1'b1;
                    end
                end
                LOAD: begin
                    state      <= ACCUM;
                    in_ready_q <= 1'b1;
                end
                ACCUM: begin
                    if (in_fire) begin
                        if (beat_cnt == BW'(BEATS - 1)) begin
                            beat_cnt   <= '0;
                            in_ready_q <= 1'b0;
                            if (kb_cnt == KW'(KB - 1)) begin
                                state        <= DRAIN;
                                out_valid_q  <= 1'b1;
                                out_is_par_q <= 1'b1;
                                out_last_q   <= (DRAIN_BEATS == 1);
                            end else begin
                                kb_cnt <= kb_cnt + 1'b1;
                                state  <= LOAD;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (out_last_q) begin
                            drain_cnt    <= '0;
                            kb_cnt       <= '0;
                            out_valid_q  <= 1'b0;
                            out_last_q   <= 1'b0;
                            out_is_par_q <= 1'b0;
                            busy_q       <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            drain_cnt  <= drain_cnt + 1'b1;
                            out_last_q <= (drain_cnt == DW'(DRAIN_BEATS - 2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qc_ldpc_encoder.sv
// ----------------------------------------------------------------------------
// tb_qc_ldpc_encoder
//   Self-checking bench for qc_ldpc_encoder (Z=16, P=4, KB=2, MB=2).
//   Expected parity comes from a bit-level reference: for every set info bit
//   t of column kb, acc[mb][i] ^= g[kb][mb][(i-t) mod Z].
//   Generator rows: g[0][0]=0001 (identity), g[1][0]=0002 (rotate by 1),
//   g[0][1], g[1][1] arbitrary.
// ----------------------------------------------------------------------------
module tb_qc_ldpc_encoder;

    localparam int Z           = 16;
    localparam int P           = 4;
    localparam int KB          = 2;
    localparam int MB          = 2;
    localparam int BEATS       = Z / P;
    localparam int DRAIN_BEATS = MB * BEATS;
    localparam int IN_WORDS    = KB * BEATS;
    localparam int MAX_CYC     = 600;

    localparam logic [KB*MB-1:0][Z-1:0] GEN = {16'h1E6B, 16'h0002, 16'hA5C3, 16'h0001};

`ifdef QC_ENC_SYSTEMATIC_EN
    localparam bit SYS = 1'b1;
`else
    localparam bit SYS = 1'b0;
`endif

    typedef logic [KB-1:0][Z-1:0] info_t;
    typedef logic [MB-1:0][Z-1:0] par_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [P-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [P-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_is_parity;
    logic         out_last;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [P-1:0] cap_data[$];
    bit           cap_par[$];
    bit           cap_last[$];
    int           cap_off;

    qc_ldpc_encoder #(
        .Z        (Z),
        .P        (P),
        .KB       (KB),
        .MB       (MB),
        .GEN_ROWS (GEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_is_parity (out_is_parity),
        .out_last      (out_last),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic par_t ref_parity(input info_t info);
        par_t par;
        logic [Z-1:0] g;
        par = '0;
        for (int kb = 0; kb < KB; kb++) begin
            for (int mb = 0; mb < MB; mb++) begin
                g = GEN[kb*MB + mb];
                for (int t = 0; t < Z; t++) begin
                    if (info[kb][t]) begin
                        for (int i = 0; i < Z; i++) begin
                            par[mb][i] = par[mb][i] ^ g[(i - t + Z) % Z];
                        end
                    end
                end
            end
        end
        return par;
    endfunction

    task automatic run_frame(input info_t info, input bit gaps, input string name);
        logic [P-1:0] words[IN_WORDS];
        logic [MB*Z-1:0] pflat;
        logic [P-1:0] exp_d[$];
        bit           exp_p[$];
        bit           exp_l[$];
        logic [P-1:0] held_data;
        bit           held;
        bit           in_f;
        bit           out_f;
        int           idx;
        int           cycles;
        int           last_in_cyc;
        int           first_par_cyc;
        int           n_cmp;

        for (int w = 0; w < IN_WORDS; w++) begin
            words[w] = info[w / BEATS][(w % BEATS)*P +: P];
        end
        pflat = ref_parity(info);
        if (SYS) begin
            for (int w = 0; w < IN_WORDS; w++) begin
                exp_d.push_back(words[w]);
                exp_p.push_back(1'b0);
                exp_l.push_back(1'b0);
            end
        end
        for (int n = 0; n < DRAIN_BEATS; n++) begin
            exp_d.push_back(pflat[n*P +: P]);
            exp_p.push_back(1'b1);
            exp_l.push_back(n == DRAIN_BEATS - 1);
        end

        cap_data.delete();
        cap_par.delete();
        cap_last.delete();
        cap_off = SYS ? IN_WORDS : 0;
        idx = 0;
        cycles = 0;
        last_in_cyc = -1;
        first_par_cyc = -1;
        held = 1'b0;
        held_data = '0;

        while (cap_data.size() < exp_d.size() && cycles < MAX_CYC) begin
            in_valid  = (idx < IN_WORDS) && (!gaps || $urandom_range(0, 3) != 0);
            in_data   = in_valid ? words[idx] : P'($urandom);
            out_ready = !gaps || ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (held) begin
                check_eq({name, "_stall_valid"}, 32'(out_valid), 32'd1);
                check_eq({name, "_stall_data"}, 32'(out_data), 32'(held_data));
            end
            if (out_valid && out_is_parity && first_par_cyc < 0) first_par_cyc = cycles;
            in_f  = in_valid && in_ready;
            out_f = out_valid && out_ready;
            if (out_f) begin
                cap_data.push_back(out_data);
                cap_par.push_back(out_is_parity);
                cap_last.push_back(out_last);
            end
            held = out_valid && !out_ready && out_is_parity;
            held_data = out_data;
            if (in_f) begin
                idx++;
                last_in_cyc = cycles;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        check_eq({name, "_in_time"}, 32'(cycles < MAX_CYC), 32'd1);
        check_eq({name, "_words"}, 32'(cap_data.size()), 32'(exp_d.size()));
        check_eq({name, "_latency"}, 32'(first_par_cyc - last_in_cyc), 32'd1);
        check_eq({name, "_idle_after"}, 32'(busy), 32'd0);
        n_cmp = (cap_data.size() < exp_d.size()) ? cap_data.size() : exp_d.size();
        for (int n = 0; n < n_cmp; n++) begin
            check_eq($sformatf("%s_data%0d", name, n), 32'(cap_data[n]), 32'(exp_d[n]));
            check_eq($sformatf("%s_par%0d", name, n), 32'(cap_par[n]), 32'(exp_p[n]));
            check_eq($sformatf("%s_last%0d", name, n), 32'(cap_last[n]), 32'(exp_l[n]));
        end
    endtask

    task automatic check_block0(input string name, input logic [Z-1:0] expect_par);
        for (int n = 0; n < BEATS; n++) begin
            if (cap_data.size() > cap_off + n) begin
                check_eq($sformatf("%s_blk0_w%0d", name, n), 32'(cap_data[cap_off + n]),
                         32'(expect_par[n*P +: P]));
            end else begin
                check_eq($sformatf("%s_blk0_w%0d_missing", name, n), 32'd0, 32'd1);
            end
        end
    endtask

    task automatic reset_mid_frame(input info_t info);
        bit f;
        bit got_first;
        got_first = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = info[0][P-1:0];
        for (int c = 0; c < 10 && !got_first; c++) begin
            @(negedge clk);
            f = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (f) got_first = 1'b1;
        end
        check_eq("rst_mid_first_beat", 32'(got_first), 32'd1);
        in_data = info[0][2*P-1:P];
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mid_out_last", 32'(out_last), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_mid_still_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        info_t info;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_in_ready", 32'(in_ready), 32'd0);
        check_eq("reset_out_valid", 32'(out_valid), 32'd0);
        check_eq("reset_out_last", 32'(out_last), 32'd0);
        check_eq("reset_out_is_parity", 32'(out_is_parity), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("idle_no_valid_busy", 32'(busy), 32'd0);

        info = {16'h0000, 16'h1234};
        run_frame(info, 1'b0, "ident");
        check_block0("ident", 16'h1234);

        info = {16'h8001, 16'h0000};
        run_frame(info, 1'b0, "shift");
        check_block0("shift", 16'h0003);

        info = {16'hFFFF, 16'hFFFF};
        run_frame(info, 1'b0, "linear");
        check_block0("linear", 16'h0000);

        info = {16'($urandom), 16'($urandom)};
        run_frame(info, 1'b1, "bp_gap");
        run_frame(info, 1'b0, "bp_full");

        info = {16'($urandom), 16'($urandom)};
        reset_mid_frame(info);
        run_frame(info, 1'b0, "after_rst");

        for (int f = 0; f < 40; f++) begin
            info = {16'($urandom), 16'($urandom)};
            run_frame(info, f[0], $sformatf("rnd%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
